// File: rtl/serial_fifo_bridge_if.sv
// Handshake and status bundle between the serial FIFO bridge, the host byte stream and the CPU serial port.
// The slave modport is the bridge's view; master is the surrounding environment.
interface serial_fifo_bridge_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic [7:0]    host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [7:0]    cpu_serial_in;
  logic          cpu_valid_in;
  logic          cpu_rden;
  logic [7:0]    cpu_serial_out;
  logic          cpu_wren;
  logic          cpu_ready_in;
  logic [7:0]    host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic          clr_flags;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          tx_overflow;
  logic          rx_underflow;

  modport master (
    output host_rx_data, host_rx_valid, cpu_rden, cpu_serial_out, cpu_wren,
           host_tx_ready, clr_flags,
    input  host_rx_ready, cpu_serial_in, cpu_valid_in, cpu_ready_in, host_tx_data,
           host_tx_valid, rx_count, tx_count, tx_overflow, rx_underflow
  );

  modport slave (
    input  host_rx_data, host_rx_valid, cpu_rden, cpu_serial_out, cpu_wren,
           host_tx_ready, clr_flags,
    output host_rx_ready, cpu_serial_in, cpu_valid_in, cpu_ready_in, host_tx_data,
           host_tx_valid, rx_count, tx_count, tx_overflow, rx_underflow
  );
endinterface

// File: rtl/serial_fifo_bridge.sv
// Two independent first-word-fall-through byte FIFOs bridging a host byte stream and the CPU serial port.
// RX: host -> CPU, TX: CPU -> host. Ready/valid are registered alongside the occupancy counts.
module serial_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic               clock,
  input  logic               reset,
  serial_fifo_bridge_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count, rx_count_nxt;
  logic          rx_ready, rx_valid, rx_push, rx_pop, rx_under;

  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count, tx_count_nxt;
  logic          tx_ready, tx_valid, tx_push, tx_pop, tx_over;

  assign rx_push = bus.host_rx_valid & rx_ready;
  assign rx_pop  = bus.cpu_rden & rx_valid;
  assign tx_push = bus.cpu_wren & tx_ready;
  assign tx_pop  = bus.host_tx_ready & tx_valid;

  // Occupancy next-state; a simultaneous push and pop cancel out.
  always_comb begin
    rx_count_nxt = rx_count;
    tx_count_nxt = tx_count;
    if (rx_push && !rx_pop)      rx_count_nxt = rx_count + CW'(1);
    else if (rx_pop && !rx_push) rx_count_nxt = rx_count - CW'(1);
    if (tx_push && !tx_pop)      tx_count_nxt = tx_count + CW'(1);
    else if (tx_pop && !tx_push) tx_count_nxt = tx_count - CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_ready  <= 1'b1;
      rx_valid  <= 1'b0;
      rx_under  <= 1'b0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_ready  <= 1'b1;
      tx_valid  <= 1'b0;
      tx_over   <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      rx_count <= rx_count_nxt;
      rx_ready <= (rx_count_nxt != FULL);
      rx_valid <= (rx_count_nxt != '0);

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      tx_count <= tx_count_nxt;
      tx_ready <= (tx_count_nxt != FULL);
      tx_valid <= (tx_count_nxt != '0);

      // Sticky error flags; a new error in the clearing cycle keeps the flag set.
      if (bus.cpu_rden && !rx_valid) rx_under <= 1'b1;
      else if (bus.clr_flags)        rx_under <= 1'b0;
      if (bus.cpu_wren && !tx_ready) tx_over  <= 1'b1;
      else if (bus.clr_flags)        tx_over  <= 1'b0;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.host_rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.cpu_serial_out;
  end

  assign bus.host_rx_ready = rx_ready;
  assign bus.cpu_valid_in  = rx_valid;
  assign bus.cpu_serial_in = rx_mem[rx_rd_ptr];
  assign bus.rx_count      = rx_count;
  assign bus.rx_underflow  = rx_under;
  assign bus.cpu_ready_in  = tx_ready;
  assign bus.host_tx_valid = tx_valid;
  assign bus.host_tx_data  = tx_mem[tx_rd_ptr];
  assign bus.tx_count      = tx_count;
  assign bus.tx_overflow   = tx_over;
endmodule
